bit_logic_pipe: RTL and testbench

BIT_LOGIC_PIPE -- requirements
Module: bit_logic_pipe

---
 rtl/bit_logic_pipe.sv | 131 +++++++++++++
 tb/tb_bit_logic_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_logic_pipe.sv
// bit_logic_pipe: two-stage valid/ready pipeline applying a per-bit logic
// function (AND / OR / XOR / NAND) to two WIDTH-bit operands.
// Stage 1 captures the request; stage 2 computes and registers the result.
// Optional feature: define BIT_LOGIC_PIPE_ZERO_FLAG_EN to add the registered
// 'zero' output (result is all zeros), held at 1 while in reset.
module bit_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result;
  logic             s1_load;
  logic             s2_load;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // Handshake: stage 2 advances when its slot is free or being drained;
  // stage 1 advances when empty or when stage 2 takes its contents.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // Per-bit logic function of the stage-1 contents.
  always_comb begin
    result = '0;
    case (op_q)
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      OP_XOR:  result = a_q ^ b_q;
      OP_NAND: result = ~(a_q & b_q);
      default: result = '0;
    endcase
  end

  // Stage 1 next state: operands only change when a request is captured.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d  = A;
        b_d  = B;
        op_d = op;
      end
    end
  end

  // Stage 2 next state: an empty stage 1 clears valid but keeps the old data.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = result;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
        zero_d = (result == '0);
`endif
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
      zero_q      <= 1'b1;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    zero      = zero_q;
`endif
  end

endmodule

// File: tb/tb_bit_logic_pipe.sv
// Directed testbench for bit_logic_pipe at WIDTH = 8, 1 and 32.
module tb_bit_logic_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic        out_ready;

  logic [7:0]  a8, b8, out8;
  logic        iv8, ir8, ov8;
  logic [0:0]  a1, b1, out1;
  logic        iv1, ir1, ov1;
  logic [31:0] a32, b32, out32;
  logic        iv32, ir32, ov32;
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
  logic        z8, z1, z32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_logic_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .op(op), .in_valid(iv8),
    .in_ready(ir8), .out(out8), .out_valid(ov8), .out_ready(out_ready)
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    , .zero(z8)
`endif
  );

  bit_logic_pipe #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .op(op), .in_valid(iv1),
    .in_ready(ir1), .out(out1), .out_valid(ov1), .out_ready(out_ready)
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    , .zero(z1)
`endif
  );

  bit_logic_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .op(op), .in_valid(iv32),
    .in_ready(ir32), .out(out32), .out_valid(ov32), .out_ready(out_ready)
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    , .zero(z32)
`endif
  );

  function automatic logic [63:0] ref_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp8 [4];

  initial begin
    exp8 = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    rst = 1'b1; op = 2'b00; out_ready = 1'b0;
    iv8 = 1'b0; iv1 = 1'b0; iv32 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a32 = '0; b32 = '0;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {63'd0, ov8}, 64'd0);
    check("rst_out", {56'd0, out8}, 64'd0);
    check("rst_in_ready", {63'd0, ir8}, 64'd1);
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    check("rst_zero", {63'd0, z8}, 64'd1);
`endif
    rst = 1'b0;
    check("post_rst_in_ready", {63'd0, ir8}, 64'd1);

    // Back-to-back ops with out_ready held high, all three widths
    out_ready = 1'b1;
    a8 = 8'hF0; b8 = 8'h3C;
    a1 = 1'b1;  b1 = 1'b0;
    a32 = 32'hF0F0_A5A5; b32 = 32'h3C3C_0FF0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        iv8 = 1'b1; iv1 = 1'b1; iv32 = 1'b1; op = 2'(c);
      end else begin
        iv8 = 1'b0; iv1 = 1'b0; iv32 = 1'b0;
      end
      check("stream_in_ready", {63'd0, ir8}, 64'd1);
      tick();
      if (c >= 1) begin
        check("stream_ov8", {63'd0, ov8}, 64'd1);
        check("stream_out8", {56'd0, out8}, {56'd0, exp8[c-1]});
        check("stream_ov1", {63'd0, ov1}, 64'd1);
        check("stream_out1", {63'd0, out1},
              ref_fn({63'd0, a1}, {63'd0, b1}, 2'(c-1)) & 64'h1);
        check("stream_ov32", {63'd0, ov32}, 64'd1);
        check("stream_out32", {32'd0, out32},
              ref_fn({32'd0, a32}, {32'd0, b32}, 2'(c-1)) & 64'hFFFF_FFFF);
      end else begin
        check("stream_ov8_first", {63'd0, ov8}, 64'd0);
      end
    end
    tick();
    check("drain_ov8", {63'd0, ov8}, 64'd0);
    check("drain_out8_hold", {56'd0, out8}, 64'hCF);

    // Back-pressure: out_ready low, in_valid high every cycle
    out_ready = 1'b0;
    iv8 = 1'b1; a8 = 8'h01; b8 = 8'h03; op = 2'b00;
    check("bp_ready0", {63'd0, ir8}, 64'd1);
    tick();
    a8 = 8'h10; b8 = 8'h01; op = 2'b01;
    check("bp_ready1", {63'd0, ir8}, 64'd1);
    tick();
    check("bp_ov_first", {63'd0, ov8}, 64'd1);
    check("bp_out_first", {56'd0, out8}, 64'h01);
    check("bp_ready_full", {63'd0, ir8}, 64'd0);
    a8 = 8'h77; b8 = 8'h77; op = 2'b11;
    tick();
    check("bp_hold_ov", {63'd0, ov8}, 64'd1);
    check("bp_hold_out", {56'd0, out8}, 64'h01);
    check("bp_still_full", {63'd0, ir8}, 64'd0);
    a8 = 8'hFF; b8 = 8'h0F; op = 2'b10;
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", {63'd0, ir8}, 64'd1);
    tick();
    iv8 = 1'b0;
    check("bp_out_second", {56'd0, out8}, 64'h11);
    tick();
    check("bp_out_third", {56'd0, out8}, 64'hF0);
    check("bp_ov_third", {63'd0, ov8}, 64'd1);
    tick();
    check("bp_empty", {63'd0, ov8}, 64'd0);

    // Reset mid-flight
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; op = 2'b00;
    tick();
    iv8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_ov", {63'd0, ov8}, 64'd0);
    check("midrst_out", {56'd0, out8}, 64'd0);
    check("midrst_in_ready", {63'd0, ir8}, 64'd1);
    tick();
    rst = 1'b0;
    check("midrst_release_ready", {63'd0, ir8}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst_no_ghost", {63'd0, ov8}, 64'd0);
    end
    iv8 = 1'b1; a8 = 8'h5A; b8 = 8'h0F; op = 2'b01;
    tick();
    iv8 = 1'b0;
    tick();
    check("midrst_new_ov", {63'd0, ov8}, 64'd1);
    check("midrst_new_out", {56'd0, out8}, 64'h5F);

    // Complementary operands: AND gives zero, OR gives all ones
    iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; op = 2'b00;
    tick();
    op = 2'b01;
    tick();
    iv8 = 1'b0;
    check("zf_and_out", {56'd0, out8}, 64'h00);
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    check("zf_and_zero", {63'd0, z8}, 64'd1);
`endif
    tick();
    check("zf_or_out", {56'd0, out8}, 64'hFF);
`ifdef BIT_LOGIC_PIPE_ZERO_FLAG_EN
    check("zf_or_zero", {63'd0, z8}, 64'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
